serial_add_ctrl: RTL and testbench

Bit-serial add controller that sequences the external gate-level 1-bit full adder (`addbit`) to add two WIDTH-bit operands, one bit per clock, LSB first. It holds the operands in shift registers, feeds one bit pair plus the carry to the adder each cycle, and captures the adder's sum/carry back. It sits between a requester using a start/done handshake and a single shared 1-bit adder instance.

---
 rtl/serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external 1-bit full adder LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the `sub` port).
`timescale 1ns/1ps

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] acc_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] b_load_d;
    logic             carry_load_d;
    logic [WIDTH-1:0] acc_next_d;

    // Operand B and the initial carry as loaded on an accepted start.
    always_comb begin
        b_load_d     = b;
        carry_load_d = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load_d     = ~b;
            carry_load_d = 1'b1;
        end
`endif
    end

    assign acc_next_d = {fa_sum, acc_sr_q[WIDTH-1:1]};

    // Handshake: start is accepted on a rising edge only in IDLE or DONE, with
    // a/b/cin sampled on that same edge; start in RUN is dropped. done is a
    // single-cycle registered pulse, and sum/cout stay valid from it until the
    // next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            acc_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        a_sr_q  <= a;
                        b_sr_q  <= b_load_d;
                        carry_q <= carry_load_d;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_sr_q <= acc_next_d;
                    carry_q  <= fa_co;
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + 1'b1;
                    // The last bit is folded into the result on the same edge it is produced.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= acc_next_d;
                        cout_q  <= fa_co;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // busy_q mirrors RUN, so the adder inputs read zero outside an operation.
    assign fa_a  = busy_q & a_sr_q[0];
    assign fa_b  = busy_q & b_sr_q[0];
    assign fa_ci = busy_q & carry_q;

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full adder and a queue-based scoreboard.
`timescale 1ns/1ps

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_ci;
  logic         fa_sum;
  logic         fa_co;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  logic [W:0] exp_q[$];
  int         exp_cyc_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .cin        (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub        (sub),
`endif
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .cout       (cout),
    .fa_a       (fa_a),
    .fa_b       (fa_b),
    .fa_ci      (fa_ci),
    .fa_sum     (fa_sum),
    .fa_co      (fa_co),
    .dbg_state_o(dbg_state)
  );

  // external 1-bit full adder
  assign fa_sum = fa_a ^ fa_b ^ fa_ci;
  assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: present one request for a single edge
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input logic [W-1:0] es, input logic ec, input bit push);
    @(negedge clk);
    a = av;
    b = bv;
    cin = ci;
    start = 1'b1;
    if (push) begin
      exp_q.push_back({ec, es});
      exp_cyc_q.push_back(cyc + 1 + W);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    check(name, exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_single_cycle", prev_done, 1'b0);
      check("fa_zero_in_done", {fa_a, fa_b, fa_ci}, 3'b000);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done: got sum=0x%0h cout=%0b expected no done", sum, cout);
      end else begin
        logic [W:0] e;
        int ecyc;
        e = exp_q.pop_front();
        ecyc = exp_cyc_q.pop_front();
        check("result", {cout, sum}, e);
        check("done_cycle", cyc, ecyc);
      end
    end
    prev_done = done;
  end

  initial begin
    int busy_cnt;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum_cout", {cout, sum}, 9'h000);
    check("rst_fa", {fa_a, fa_b, fa_ci}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic add and busy length
    issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) break;
    end
    check("busy_cycles", busy_cnt, 8);
    drain("drain_add");
    @(negedge clk);
    check("done_low_after_pulse", done, 1'b0);
    check("sum_held", {cout, sum}, 9'h096);

    // carry ripple through every bit, adder inputs during RUN
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("fa_first_bit", {fa_a, fa_b, fa_ci}, 3'b110);
    @(negedge clk);
    check("fa_second_bit", {fa_a, fa_b, fa_ci}, 3'b101);
    drain("drain_carry");
    issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1);
    drain("drain_cin");

    // start during RUN is ignored
    issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    issue(8'h11, 8'h22, 1'b1, 8'h00, 1'b0, 1'b0);
    drain("drain_ignore");
    repeat (12) @(posedge clk);

    // reset mid-RUN
    issue(8'hC3, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_sum_cout", {cout, sum}, 9'h000);
    check("mid_rst_fa", {fa_a, fa_b, fa_ci}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1);
    drain("drain_after_rst");

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h0F;
    b = 8'h01;
    cin = 1'b0;
    start = 1'b1;
    exp_q.push_back({1'b0, 8'h10});
    exp_cyc_q.push_back(cyc + 1 + W);
    exp_q.push_back({1'b1, 8'h00});
    exp_cyc_q.push_back(cyc + 1 + W + W + 1);
    @(posedge clk);
    #1;
    a = 8'h80;
    b = 8'h80;
    repeat (W + 1) @(posedge clk);
    #1 start = 1'b0;
    drain("drain_b2b");

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b1);
    drain("drain_sub1");
    issue(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b1);
    drain("drain_sub2");
    sub = 1'b0;
    issue(8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b1);
    drain("drain_sub_off");
`endif

    repeat (12) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
